// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between NREQ byte sources
// Optional feature macro: UART_ARB_LOCK_EN (hold the grant on one requester until a byte with req_last=1)
module uart_tx_arbiter #(
  parameter int NREQ           = 2,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_word,
  output logic              tx_start,
  input  logic              tx_done,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              timeout_err
);

  localparam int PW   = (NREQ < 2) ? 1 : $clog2(NREQ);
  localparam int MAXC = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GAP} state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   cur_q;
  logic [CW-1:0]   cnt_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] ready_q;
  logic [7:0]      word_q;
  logic            start_q;
  logic            busy_q;
  logic            err_q;
  logic            locked;

  logic [7:0]      req_bytes [NREQ];
  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   ptr_next;
  logic            to_hit;

`ifdef UART_ARB_LOCK_EN
  logic            lock_q;
  logic            last_q;
  assign locked = lock_q;
`else
  logic            unused_last;
  assign locked      = 1'b0;
  assign unused_last = ^req_last;
`endif

  // Split the flat data bus into one byte per requester
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_bytes[i] = req_data[8*i +: 8];
    end
  end

  // First valid requester at or after the pointer; while locked only the pointer itself qualifies
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr_q) + k) % NREQ);
      if (req_valid[cand] && (k == 0 || !locked)) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign ptr_next = (cur_q == PW'(NREQ - 1)) ? '0 : cur_q + PW'(1);
  assign to_hit   = (TIMEOUT_CYCLES > 0) && (cnt_q == TO_LAST);

  // Arbitration FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      ready_q <= '0;
      word_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
`endif
    end else begin
      ready_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            grant_q <= NREQ'(1) << pick_idx;
            ready_q <= NREQ'(1) << pick_idx;
            word_q  <= req_bytes[pick_idx];
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            cur_q   <= pick_idx;
            cnt_q   <= '0;
            state_q <= ST_WAIT;
`ifdef UART_ARB_LOCK_EN
            last_q  <= req_last[pick_idx];
`endif
          end
        end
        ST_WAIT: begin
          if (tx_done || to_hit) begin
            start_q <= 1'b0;
            grant_q <= '0;
            cnt_q   <= '0;
            if (!tx_done) err_q <= 1'b1;
`ifdef UART_ARB_LOCK_EN
            // A timeout always releases the lock so a dead transmitter cannot starve others
            if (last_q || !tx_done) begin
              ptr_q  <= ptr_next;
              lock_q <= 1'b0;
            end else begin
              ptr_q  <= cur_q;
              lock_q <= 1'b1;
            end
`else
            ptr_q   <= ptr_next;
`endif
            if (GAP_CYCLES > 0) begin
              state_q <= ST_GAP;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else if (TIMEOUT_CYCLES > 0) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = ready_q;
  assign tx_word     = word_q;
  assign tx_start    = start_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [7:0]  tx_word;
  logic        tx_start;
  logic        tx_done;
  logic [1:0]  grant;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(2), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_word     (tx_word),
    .tx_start    (tx_start),
    .tx_done     (tx_done),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for tx_start, capture the byte, then answer with tx_done after dly clocks
  task automatic serve_byte(input int dly, output logic [7:0] w, output logic [1:0] g, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    w = tx_word;
    g = grant;
    repeat (dly) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  logic [7:0] w;
  logic [1:0] g;
  logic       ok;
  int         cnt_a;
  int         cnt_b;
  int         idx0;
  logic [7:0] t2_word [4];
  logic [1:0] t2_grant [4];
  logic [7:0] seq0 [3];
  logic       last0 [3];
  logic [7:0] t5_word [4];

  initial begin
    t2_word  = '{8'hAA, 8'h55, 8'hAA, 8'h55};
    t2_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
    seq0     = '{8'h31, 8'h32, 8'h33};
    last0    = '{1'b0, 1'b0, 1'b1};
`ifdef UART_ARB_LOCK_EN
    t5_word  = '{8'h31, 8'h32, 8'h33, 8'h55};
`else
    t5_word  = '{8'h31, 8'h55, 8'h32, 8'h33};
`endif

    rst = 1'b1; req_valid = '0; req_data = '0; req_last = 2'b11; tx_done = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_start", tx_start, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_err", timeout_err, 0);
    check_eq("rst_word", tx_word, 0);
    rst = 1'b0;

    // single byte, done 10 clocks after start, gap of 2
    @(negedge clk);
    req_valid = 2'b01; req_data[7:0] = 8'h41;
    @(negedge clk);
    check_eq("t1_start", tx_start, 1);
    check_eq("t1_ready", req_ready, 2'b01);
    check_eq("t1_grant", grant, 2'b01);
    check_eq("t1_word", tx_word, 8'h41);
    check_eq("t1_busy", busy, 1);
    cnt_a = int'(req_ready[0]);
    cnt_b = 0;
    req_valid = '0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (!tx_start) cnt_b++;
      cnt_a += int'(req_ready[0]);
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check_eq("t1_start_low_early", cnt_b, 0);
    check_eq("t1_start_after_done", tx_start, 0);
    check_eq("t1_grant_after_done", grant, 0);
    check_eq("t1_busy_gap1", busy, 1);
    cnt_a += int'(req_ready[0]);
    @(negedge clk);
    check_eq("t1_busy_gap2", busy, 1);
    @(negedge clk);
    check_eq("t1_busy_idle", busy, 0);
    check_eq("t1_ready_pulses", cnt_a, 1);

    // tx_done while idle is ignored
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check_eq("t6_busy", busy, 0);
    check_eq("t6_start", tx_start, 0);
    check_eq("t6_err", timeout_err, 0);
    @(negedge clk);
    check_eq("t6_busy_later", busy, 0);

    // both requesters continuously valid alternate
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    req_data = {8'h55, 8'hAA}; req_valid = 2'b11;
    for (int b = 0; b < 4; b++) begin
      serve_byte(3, w, g, ok);
      check_eq($sformatf("t2_seen%0d", b), ok, 1);
      check_eq($sformatf("t2_word%0d", b), w, t2_word[b]);
      check_eq($sformatf("t2_grant%0d", b), g, t2_grant[b]);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);

    // timeout after 16 WAIT clocks, then pending byte goes out
    req_data[7:0] = 8'h77; req_valid = 2'b01;
    @(negedge clk);
    check_eq("t3_start", tx_start, 1);
    check_eq("t3_ready", req_ready, 2'b01);
    req_valid = 2'b10; req_data[15:8] = 8'h99;
    cnt_a = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (tx_start) cnt_a++;
    end
    check_eq("t3_start_held", cnt_a, 15);
    check_eq("t3_err_before", timeout_err, 0);
    @(negedge clk);
    check_eq("t3_start_fall", tx_start, 0);
    check_eq("t3_grant_fall", grant, 0);
    check_eq("t3_err_set", timeout_err, 1);
    serve_byte(2, w, g, ok);
    req_valid = '0;
    check_eq("t3_next_seen", ok, 1);
    check_eq("t3_next_word", w, 8'h99);
    check_eq("t3_next_grant", g, 2'b10);
    check_eq("t3_err_sticky", timeout_err, 1);
    repeat (3) @(negedge clk);

    // async reset mid-WAIT with pointer at 1
    req_data[7:0] = 8'h10; req_valid = 2'b01;
    serve_byte(2, w, g, ok);
    req_valid = '0;
    check_eq("t4_pre_grant", g, 2'b01);
    repeat (3) @(negedge clk);
    req_data[15:8] = 8'h66; req_valid = 2'b10;
    @(negedge clk);
    check_eq("t4_wait_grant", grant, 2'b10);
    check_eq("t4_wait_ready", req_ready, 2'b10);
    req_valid = '0;
    #1 rst = 1'b1;
    #1;
    check_eq("t4_start", tx_start, 0);
    check_eq("t4_grant", grant, 0);
    check_eq("t4_busy", busy, 0);
    check_eq("t4_ready", req_ready, 0);
    check_eq("t4_err", timeout_err, 0);
    #1 rst = 1'b0;
    req_data = {8'hB1, 8'hA0}; req_valid = 2'b11;
    serve_byte(2, w, g, ok);
    req_valid = '0;
    check_eq("t4_after_grant", g, 2'b01);
    check_eq("t4_after_word", w, 8'hA0);
    repeat (3) @(negedge clk);

    // message lock: req0 sends 31,32,33 while req1 holds 55
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    idx0 = 0;
    req_data = {8'h55, seq0[0]}; req_last = {1'b1, last0[0]}; req_valid = 2'b11;
    for (int b = 0; b < 4; b++) begin
      serve_byte(2, w, g, ok);
      check_eq($sformatf("t5_word%0d", b), w, t5_word[b]);
      if (g[0]) begin
        idx0++;
        if (idx0 >= 3) begin
          req_valid[0] = 1'b0;
        end else begin
          req_data[7:0] = seq0[idx0];
          req_last[0]   = last0[idx0];
        end
      end
      if (g[1]) req_valid[1] = 1'b0;
    end
    req_valid = '0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
